// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//   Eight-phase instruction sequencer for the RISC core. Steps through the
//   instruction phases and decodes the address-mux select and every memory,
//   IR, PC and accumulator strobe from the registered phase, the IR opcode
//   and the accumulator-zero flag. Read phases can stall on mem_ready, and a
//   HLT instruction freezes the sequencer until reset.
//
//   State table (phase | meaning):
//     0 INST_ADDR  | PC drives the address bus
//     1 INST_FETCH | instruction read (waits for mem_ready when stalling)
//     2 INST_LOAD  | instruction captured into IR
//     3 IDLE       | IR load held, read still asserted
//     4 OP_ADDR    | IR operand address drives the bus, PC increments
//     5 OP_FETCH   | operand read (waits for mem_ready on ALU ops)
//     6 ALU_OP     | ALU operates / store data driven / skip or jump
//     7 STORE      | accumulator load, memory write or PC load
//
// Parameters:
//   STALL_EN  1: FETCH phases wait for mem_ready; 0: mem_ready ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   opcode     IR opcode (HLT,SKZ,ADD,AND,XOR,LDA,STO,JMP = 0..7)
//   zero       accumulator-zero flag
//   mem_ready  memory read data valid this cycle
//   phase      current phase 0..7
//   sel        address mux select (1 = PC, 0 = IR operand address)
//   rd         memory read enable
//   ld_ir      instruction register load
//   halt       processor halted (sticky until reset)
//   inc_pc     PC increment
//   ld_ac      accumulator load
//   ld_pc      PC load (jump)
//   wr         memory write
//   data_e     data bus drive enable
// -----------------------------------------------------------------------------
module cpu_sequencer #(
  parameter bit STALL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] phase,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       wr,
  output logic       data_e
);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  phase_t state_q, state_d;
  logic   halted_q, halted_d;
  logic   aluop;
  logic   is_hlt;

  // Instructions that read an operand from memory into the accumulator.
  assign aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign is_hlt = (opcode == OP_HLT);

  assign phase = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Next-phase logic. Holding the phase is enough to hold every output,
  // since all strobes are decoded from the registered phase.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (!halted_q) begin
      case (state_q)
        INST_FETCH: begin
          if (!STALL_EN || mem_ready) state_d = INST_LOAD;
        end
        OP_ADDR: begin
          if (is_hlt) halted_d = 1'b1;
          else        state_d  = OP_FETCH;
        end
        OP_FETCH: begin
          // Only ALU ops actually consume read data here.
          if (!STALL_EN || !aluop || mem_ready) state_d = ALU_OP;
        end
        default: state_d = phase_t'(state_q + 3'd1);
      endcase
    end
  end

  // Strobe decode (Moore on phase, qualified by opcode/zero in phases 4-7).
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (state_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          // HLT is flagged in the same cycle it is decoded, ahead of the
          // sticky flag that sets on the following edge.
          if (is_hlt) halt   = 1'b1;
          else        inc_pc = 1'b1;
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
          wr     = (opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst2_n = 1'b0;
  logic [2:0] opcode = 3'd2;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic [2:0] phase;
  logic sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;

  logic [2:0] phase2;
  logic sel2, rd2, ld_ir2, halt2, inc_pc2, ld_ac2, ld_pc2, wr2, data_e2;

  int total = 0;
  int bad = 0;

  // {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e}
  logic [8:0] outs;
  assign outs = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};

  localparam logic [8:0] E_P0   = 9'b100000000;
  localparam logic [8:0] E_P1   = 9'b110000000;
  localparam logic [8:0] E_P23  = 9'b111000000;
  localparam logic [8:0] E_NONE = 9'b000000000;
  localparam logic [8:0] E_INC  = 9'b000010000;
  localparam logic [8:0] E_RD   = 9'b010000000;
  localparam logic [8:0] E_RDAC = 9'b010001000;
  localparam logic [8:0] E_DE   = 9'b000000001;
  localparam logic [8:0] E_WRDE = 9'b000000011;
  localparam logic [8:0] E_LDPC = 9'b000000100;
  localparam logic [8:0] E_HALT = 9'b000100000;

  cpu_sequencer #(.STALL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .phase(phase), .sel(sel), .rd(rd),
    .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc), .ld_ac(ld_ac),
    .ld_pc(ld_pc), .wr(wr), .data_e(data_e)
  );

  cpu_sequencer #(.STALL_EN(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst2_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .phase(phase2), .sel(sel2), .rd(rd2),
    .ld_ir(ld_ir2), .halt(halt2), .inc_pc(inc_pc2), .ld_ac(ld_ac2),
    .ld_pc(ld_pc2), .wr(wr2), .data_e(data_e2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [2:0] opc, input logic z,
                           input logic [8:0] e4, input logic [8:0] e5,
                           input logic [8:0] e6, input logic [8:0] e7);
    logic [8:0] e [8];
    e = '{E_P0, E_P1, E_P23, E_P23, e4, e5, e6, e7};
    opcode = opc;
    zero = z;
    mem_ready = 1'b1;
    for (int p = 0; p < 8; p++) begin
      check($sformatf("%s phase p%0d", tag, p), 16'(phase), 16'(p));
      check($sformatf("%s outs p%0d", tag, p), 16'(outs), 16'(e[p]));
      step();
    end
    check($sformatf("%s wrap", tag), 16'(phase), 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("reset phase", 16'(phase), 16'd0);
    check("reset outs", 16'(outs), 16'(E_P0));
    step();
    step();
    #1 rst_n = 1'b1;
    step();
    check("post reset phase", 16'(phase), 16'd1);
    step(); step(); step(); step(); step(); step(); step();
    check("free run back to 0", 16'(phase), 16'd0);

    run_instr("add",  3'd2, 1'b0, E_INC, E_RD,   E_RD,   E_RDAC);
    run_instr("sto",  3'd6, 1'b0, E_INC, E_NONE, E_DE,   E_WRDE);
    run_instr("skz1", 3'd1, 1'b1, E_INC, E_NONE, E_INC,  E_NONE);
    run_instr("skz0", 3'd1, 1'b0, E_INC, E_NONE, E_NONE, E_NONE);
    run_instr("jmp",  3'd7, 1'b0, E_INC, E_NONE, E_LDPC, E_LDPC);
    run_instr("lda",  3'd5, 1'b1, E_INC, E_RD,   E_RD,   E_RDAC);

    // stall in phase 1
    opcode = 3'd2; zero = 1'b0;
    step();
    mem_ready = 1'b0;
    check("stall1 outs", 16'(outs), 16'(E_P1));
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall1 hold %0d", i), 16'(phase), 16'd1);
      check($sformatf("stall1 outs %0d", i), 16'(outs), 16'(E_P1));
    end
    mem_ready = 1'b1;
    check("stall1 still 1", 16'(phase), 16'd1);
    step();
    check("stall1 release", 16'(phase), 16'd2);

    // stall in phase 5 with LDA; opcode changes in phase 2 are harmless
    opcode = 3'd5;
    check("opc change p2 outs", 16'(outs), 16'(E_P23));
    step(); step(); step();
    check("stall5 at 5", 16'(phase), 16'd5);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall5 hold %0d", i), 16'(phase), 16'd5);
      check($sformatf("stall5 outs %0d", i), 16'(outs), 16'(E_RD));
    end
    mem_ready = 1'b1;
    step();
    check("stall5 release", 16'(phase), 16'd6);
    step(); step();
    check("stall5 wrap", 16'(phase), 16'd0);

    // STO ignores mem_ready in phase 5; mem_ready low elsewhere ignored too
    opcode = 3'd6;
    step(); step(); step();
    mem_ready = 1'b0;
    step();
    check("sto p3 ignore ready", 16'(phase), 16'd4);
    step();
    check("sto at 5", 16'(phase), 16'd5);
    step();
    check("sto no stall", 16'(phase), 16'd6);
    mem_ready = 1'b1;
    step(); step();
    check("sto wrap", 16'(phase), 16'd0);

    // halt
    opcode = 3'd0;
    step(); step(); step(); step();
    check("hlt phase", 16'(phase), 16'd4);
    check("hlt outs", 16'(outs), 16'(E_HALT));
    for (int i = 0; i < 20; i++) begin
      if (i == 3) opcode = 3'd2;
      if (i == 5) mem_ready = 1'b0;
      step();
    end
    check("halted phase", 16'(phase), 16'd4);
    check("halted outs", 16'(outs), 16'(E_HALT));
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("halt reset phase", 16'(phase), 16'd0);
    check("halt reset outs", 16'(outs), 16'(E_P0));
    rst_n = 1'b1;
    step();
    check("after halt reset run", 16'(phase), 16'd1);
    step(); step(); step(); step(); step(); step(); step();
    check("after halt reset wrap", 16'(phase), 16'd0);

    // async reset mid-store
    opcode = 3'd6;
    for (int i = 0; i < 7; i++) step();
    check("sto7 phase", 16'(phase), 16'd7);
    check("sto7 outs", 16'(outs), 16'(E_WRDE));
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst wr/de", 16'({wr, data_e}), 16'd0);
    check("async rst phase", 16'(phase), 16'd0);
    check("async rst outs", 16'(outs), 16'(E_P0));
    step();
    rst_n = 1'b1;

    // STALL_EN=0: never stalls even with mem_ready low
    opcode = 3'd5;
    mem_ready = 1'b0;
    #2 rst2_n = 1'b1;
    check("ns start", 16'(phase2), 16'd0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("ns phase %0d", i), 16'(phase2), 16'(i % 8));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Eight-phase instruction sequencer for the RISC core.
- Generates the address-mux select plus all memory, IR, PC and accumulator strobes from the current phase, the IR opcode and the ALU zero flag.
- It is the driving end of the address mux: `sel`=1 routes the PC, `sel`=0 routes the IR operand address.
- Adds a memory-ready stall on read phases and a sticky halt.

Parameters:
- STALL_EN, 1, when 1 the FETCH phases wait for mem_ready; when 0 mem_ready is ignored (always advance).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  3  IR opcode: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- zero  input  1  accumulator-zero flag.
- mem_ready  input  1  memory read data valid this cycle.
- phase  output  3  current phase, 0..7.
- sel  output  1  address mux select (1=PC, 0=IR address).
- rd  output  1  memory read enable.
- ld_ir  output  1  instruction register load.
- halt  output  1  processor halted (sticky).
- inc_pc  output  1  PC increment.
- ld_ac  output  1  accumulator load.
- ld_pc  output  1  PC load (jump).
- wr  output  1  memory write.
- data_e  output  1  data bus drive enable.

Behaviour:
- Phases: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- Normal progression is +1 per clock, with 7 wrapping to 0.
- Reset (rst_n low, asynchronous): phase=0, halted flag cleared. Outputs follow from decode: sel=1, all other strobes 0.
- All strobes are combinational decode of the registered phase, opcode and zero (Moore on phase). No glitch-free requirement.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Decode:
  - sel=1 in phases 0-3, 0 in phases 4-7.
  - rd=1 in phases 1, 2, 3; also in 5, 6, 7 when ALUOP.
  - ld_ir=1 in phases 2, 3.
  - inc_pc=1 in phase 4 unless opcode=HLT; also in phase 6 when opcode=SKZ and zero=1.
  - ld_pc=1 in phases 6, 7 when opcode=JMP.
  - ld_ac=1 in phase 7 when ALUOP.
  - data_e=1 in phases 6, 7 when opcode=STO.
  - wr=1 in phase 7 when opcode=STO.
- Stall (STALL_EN=1):
  - In phase 1, advance only when mem_ready=1.
  - In phase 5 with ALUOP, advance only when mem_ready=1.
  - In phase 5 without ALUOP, mem_ready is ignored and the phase advances.
  - While stalled, phase and all outputs hold.
- Halt:
  - Entering phase 4 with opcode=HLT: halt=1 combinationally in that cycle.
  - On the next edge the halted flag sets and phase freezes at 4.
  - While halted: halt=1, sel=0, every other strobe 0, mem_ready and opcode ignored.
  - Only rst_n clears the halted flag.
- Opcode changes during phases 0-3 have no effect on outputs.
- Reset mid-instruction (any phase, stalled or halted) returns to phase 0 immediately, with no pending write. wr must drop asynchronously with rst_n.
- Simultaneous events:
  - mem_ready=1 outside phases 1/5 is ignored.
  - SKZ with zero=0 gives plain progression with no extra inc_pc.

Test Plan:
- Reset + free run: rst_n low→high, opcode=ADD, mem_ready=1 → phase 0→7→0 in 8 clocks.
  - sel=1 for phases 0-3, rd=1 in 1-3 and 5-7, ld_ir in 2-3, inc_pc in 4, ld_ac in 7.
- Store: opcode=STO → rd=0 in phases 5-7, data_e=1 in 6-7, wr=1 only in 7, ld_ac=0.
- Skip/jump:
  - opcode=SKZ, zero=1 → inc_pc=1 in phases 4 and 6.
  - zero=0 → inc_pc only in phase 4.
  - opcode=JMP → ld_pc=1 in phases 6-7.
- Stall:
  - mem_ready=0 for 3 clocks in phase 1 → phase holds at 1 with rd=1, then advances one clock after mem_ready=1.
  - Same stall in phase 5 with opcode=LDA.
  - Same stall with opcode=STO does not stall.
  - With STALL_EN=0, no stall occurs.
- Halt: opcode=HLT → phase 4 shows halt=1, inc_pc=0; after 20 clocks phase stays 4, halt=1, all strobes 0. Pulse rst_n → phase 0, halt=0.
- Async reset mid-store: assert rst_n low between edges in phase 7 with opcode=STO → wr and data_e drop immediately, phase=0, before the next clock edge.
